// File: rtl/comparator_seq.sv
// -----------------------------------------------------------------------------
// comparator_seq
//   Chunk-serial magnitude comparator with cascade inputs. Two WIDTH-bit
//   operands are compared CHUNK bits per clock, MSB chunk first. The compare
//   stops at the first chunk that differs. If every chunk is equal, the
//   latched cascade inputs {Li,Ei,Gi} are passed through as the result.
//
//   Optional build macro: COMPARATOR_SEQ_SIGNED_EN
//     When defined, the operands are two's complement. Bit CHUNK-1 of the MSB
//     chunk is inverted on both operands before the unsigned compare. All
//     other chunks compare unsigned. Latency and handshake do not change.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      compare request, sampled only while busy=0
//   A, B       WIDTH-bit operands, latched on an accepted start
//   Li/Ei/Gi   cascade less/equal/greater, used only when A==B
//   busy       compare in progress
//   done       one-cycle pulse, Lo/Eo/Go valid
//   Lo/Eo/Go   registered result, held until the next result is written
//   dbg_state  FSM state (0 = IDLE, 1 = RUN) for observation
//
// Handshake
//   A start is accepted on a rising edge where start=1 and busy=0. busy is 1
//   from the next cycle until the result cycle. In the result cycle done=1
//   and busy=0, so a start in that same cycle is accepted with no bubble.
//   A start while busy=1 is dropped, not queued.
// -----------------------------------------------------------------------------
module comparator_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Li,
  input  logic             Ei,
  input  logic             Gi,
  output logic             busy,
  output logic             done,
  output logic             Lo,
  output logic             Eo,
  output logic             Go,
  output logic             dbg_state
);

  // The CHUNK guard keeps the division legal, so the configuration check
  // below can report the error itself.
  localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_cfg_err
    $error("comparator_seq: WIDTH must be a non-zero multiple of CHUNK, and CHUNK must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cas_q;
  logic [KW-1:0]    k_q;
  logic             busy_q, done_q;
  logic [2:0]       res_q;       // {Lo, Eo, Go}

  logic [CHUNK-1:0] a_top, b_top;

  // The operand registers shift left after each equal chunk. This means the
  // chunk under test is always in the top CHUNK bits, and no variable part
  // select is needed.
  always_comb begin
    a_top = a_q[WIDTH-1 -: CHUNK];
    b_top = b_q[WIDTH-1 -: CHUNK];
`ifdef COMPARATOR_SEQ_SIGNED_EN
    // Inverting the sign bit maps two's complement order onto unsigned order.
    // This only applies while the MSB chunk is under test.
    if (k_q == KW'(NCHUNK - 1)) begin
      a_top[CHUNK-1] = ~a_top[CHUNK-1];
      b_top[CHUNK-1] = ~b_top[CHUNK-1];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cas_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            cas_q   <= {Li, Ei, Gi};
            k_q     <= KW'(NCHUNK - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (a_top < b_top) begin
            res_q   <= 3'b100;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (a_top > b_top) begin
            res_q   <= 3'b001;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (k_q == '0) begin
            // All chunks are equal. Pass the cascade through unmodified,
            // even if it is not one-hot.
            res_q   <= cas_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            k_q <= k_q - 1'b1;
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Lo        = res_q[2];
  assign Eo        = res_q[1];
  assign Go        = res_q[0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_comparator_seq.sv
// -----------------------------------------------------------------------------
// tb_comparator_seq
//   Directed bench for comparator_seq (WIDTH=16, CHUNK=4). Inputs are driven
//   and outputs are sampled on the falling edge. Latency is counted in
//   cycles after the accepting rising edge. Signed-mode expectations follow
//   the COMPARATOR_SEQ_SIGNED_EN macro, which is seen by both files.
// -----------------------------------------------------------------------------
module tb_comparator_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             Li, Ei, Gi;
  logic             busy, done, Lo, Eo, Go;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;
  int done_seen;

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .Li        (Li),
    .Ei        (Ei),
    .Gi        (Gi),
    .busy      (busy),
    .done      (done),
    .Lo        (Lo),
    .Eo        (Eo),
    .Go        (Go),
    .dbg_state (dbg_state)
  );

  // ---- clock -----------------------------------------------------------------
  always #5 clk = ~clk;

  // ---- checking --------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- drivers ---------------------------------------------------------------
  // Called at a falling edge. Drives the request, then advances to the
  // falling edge just after the accepting rising edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] cas, input string tag);
    A = a; B = b; {Li, Ei, Gi} = cas; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_accept"}, busy, 1'b1);
    check({tag, "_done_after_accept"}, done, 1'b0);
  endtask

  // Waits a bounded number of cycles for done, then checks latency, the
  // result, and that busy is low in the done cycle.
  task automatic wait_done(input int start_cnt, input int exp_lat,
                           input logic [2:0] exp_res, input string tag);
    int  cyc;
    bit  seen;
    cyc  = start_cnt;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, {Lo, Eo, Go}, exp_res);
    check({tag, "_busy_in_done"}, busy, 1'b0);
  endtask

  // ---- directed sequence -----------------------------------------------------
  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; {Li, Ei, Gi} = 3'b000;

    // Reset, then idle
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_res", {Lo, Eo, Go}, 3'b000);
    check("reset_state", dbg_state, 1'b0);
    rst = 1'b0;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("idle_no_done", done_seen, 0);
    check("idle_busy", busy, 1'b0);

    // Early exit on the MSB chunk
    issue(16'h9000, 16'h1FFF, 3'b000, "early");
    wait_done(0, 1, 3'b001, "early");
    @(negedge clk);
    check("done_one_pulse", done, 1'b0);
    check("hold_after_done", {Lo, Eo, Go}, 3'b001);

    // Full-length equal operands, result taken from the cascade
    issue(16'hA5A5, 16'hA5A5, 3'b010, "eq_cas_e");
    check("start_keeps_result", {Lo, Eo, Go}, 3'b001);
    wait_done(0, 4, 3'b010, "eq_cas_e");
    issue(16'hA5A5, 16'hA5A5, 3'b100, "eq_cas_l");
    wait_done(0, 4, 3'b100, "eq_cas_l");
    issue(16'h0000, 16'h0000, 3'b111, "eq_cas_111");
    wait_done(0, 4, 3'b111, "eq_cas_111");
    issue(16'hFFFF, 16'hFFFF, 3'b000, "eq_cas_000");
    wait_done(0, 4, 3'b000, "eq_cas_000");

    // Operands that differ in a low-order chunk
    issue(16'h1234, 16'h1235, 3'b010, "lsb_lt");
    wait_done(0, 4, 3'b100, "lsb_lt");
    issue(16'h1244, 16'h1235, 3'b010, "chunk1_gt");
    wait_done(0, 3, 3'b001, "chunk1_gt");
    issue(16'h1034, 16'h1235, 3'b010, "chunk2_lt");
    wait_done(0, 2, 3'b100, "chunk2_lt");

    // start held high with new operands while busy is ignored
    issue(16'h1234, 16'h1235, 3'b010, "ign");
    A = 16'hFFFF; B = 16'h0000; {Li, Ei, Gi} = 3'b001; start = 1'b1;
    @(negedge clk);
    check("ign_no_done_c1", done, 1'b0);
    @(negedge clk);
    check("ign_no_done_c2", done, 1'b0);
    start = 1'b0;
    wait_done(2, 4, 3'b100, "ign");

    // Back-to-back: start issued in the done cycle
    issue(16'h0001, 16'h0000, 3'b000, "b2b");
    check("b2b_prev_result_kept", {Lo, Eo, Go}, 3'b100);
    wait_done(0, 4, 3'b001, "b2b");

    // Reset during cycle 2 of a 4-cycle compare
    issue(16'h1234, 16'h1235, 3'b010, "rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_res", {Lo, Eo, Go}, 3'b000);
    check("rst_mid_state", dbg_state, 1'b0);
    rst = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 0);

    // Sign handling on the MSB chunk
`ifdef COMPARATOR_SEQ_SIGNED_EN
    issue(16'hFFFF, 16'h0001, 3'b000, "sgn_m1_vs_1");
    wait_done(0, 1, 3'b100, "sgn_m1_vs_1");
    issue(16'h7000, 16'h8000, 3'b000, "sgn_max_vs_min");
    wait_done(0, 1, 3'b001, "sgn_max_vs_min");
    issue(16'hF123, 16'hF124, 3'b000, "sgn_low_chunk");
    wait_done(0, 4, 3'b100, "sgn_low_chunk");
`else
    issue(16'hFFFF, 16'h0001, 3'b000, "uns_ffff_vs_1");
    wait_done(0, 1, 3'b001, "uns_ffff_vs_1");
    issue(16'h7000, 16'h8000, 3'b000, "uns_7000_vs_8000");
    wait_done(0, 1, 3'b100, "uns_7000_vs_8000");
    issue(16'hF123, 16'hF124, 3'b000, "uns_low_chunk");
    wait_done(0, 4, 3'b100, "uns_low_chunk");
`endif

    @(negedge clk);
    check("final_idle_state", dbg_state, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
